// File: rtl/spi_byte_engine.sv
// ============================================================================
// spi_byte_engine
// ----------------------------------------------------------------------------
// Byte-level SPI mode-0 transceiver placed directly after the SPI clock
// divider. It takes a byte over a valid/ready handshake, drops chip-select,
// starts the divider, shifts MOSI on slow-clock falls and samples MISO on
// slow-clock rises. The received byte comes back with a one-cycle pulse.
// This block is the only driver of the divider's configuration and start.
//
// Build option:
//   SPI_ENGINE_LSB_FIRST_EN  defined   -> bit 0 is sent first; received bits
//                                         fill from bit 7 downward.
//                            undefined -> MSB first; received bits enter at
//                                         bit 0 (default).
//
// Ports:
//   i_clk          system clock (same as the divider)
//   i_rst_n        synchronous active-low reset
//   i_tx_data      byte to transmit
//   i_tx_valid     transmit request
//   o_tx_ready     engine can accept a byte
//   o_rx_data      last received byte, held until the next completion
//   o_rx_valid     one-cycle pulse marking new o_rx_data
//   i_cdiv         slow-clock divisor D (even, 0 means 2)
//   i_cdiv_load    request to program D into the divider
//   o_div_config   divider config bus {D, load}
//   o_div_start_n  divider start, active-low
//   i_div_idle     divider idle flag
//   i_sclk         divider slow clock (idles low)
//   o_sclk         SPI SCK pin, gated by chip-select
//   o_mosi         SPI data out
//   i_miso         SPI data in
//   o_cs_n         SPI chip-select, active-low
// ============================================================================
module spi_byte_engine (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic [7:0] i_tx_data,
    input  logic       i_tx_valid,
    output logic       o_tx_ready,
    output logic [7:0] o_rx_data,
    output logic       o_rx_valid,
    input  logic [7:0] i_cdiv,
    input  logic       i_cdiv_load,
    output logic [8:0] o_div_config,
    output logic       o_div_start_n,
    input  logic       i_div_idle,
    input  logic       i_sclk,
    output logic       o_sclk,
    output logic       o_mosi,
    input  logic       i_miso,
    output logic       o_cs_n
);

    typedef enum logic [2:0] {
        ST_RESET,
        ST_IDLE,
        ST_CFG,
        ST_CFG_WAIT,
        ST_START,
        ST_SHIFT,
        ST_DONE
    } state_t;

    state_t      r_state;
    logic [7:0]  r_tx_shift;
    logic [7:0]  r_rx_shift;
    logic [3:0]  r_edge_cnt;
    logic        r_sclk_q;
    logic        r_cs_n;
    logic        r_mosi;
    logic        r_div_start_n;
    logic [8:0]  r_div_config;
    logic [7:0]  r_rx_data;
    logic        r_rx_valid;

    logic        w_in_shift;
    logic        w_rise;
    logic        w_fall;
    logic        w_tx_ready;
    logic        w_tx_first_bit;
    logic [7:0]  w_tx_rotated;
    logic        w_tx_next_bit;
    logic [7:0]  w_rx_shifted;

    // The TX register rotates rather than shifts so the bit to present next
    // always sits at the outgoing end of the rotated value.
`ifdef SPI_ENGINE_LSB_FIRST_EN
    assign w_tx_first_bit = i_tx_data[0];
    assign w_tx_rotated   = {r_tx_shift[0], r_tx_shift[7:1]};
    assign w_tx_next_bit  = w_tx_rotated[0];
    assign w_rx_shifted   = {i_miso, r_rx_shift[7:1]};
`else
    assign w_tx_first_bit = i_tx_data[7];
    assign w_tx_rotated   = {r_tx_shift[6:0], r_tx_shift[7]};
    assign w_tx_next_bit  = w_tx_rotated[7];
    assign w_rx_shifted   = {r_rx_shift[6:0], i_miso};
`endif

    assign w_in_shift = (r_state == ST_SHIFT);
    assign w_rise     = w_in_shift &  i_sclk & ~r_sclk_q;
    assign w_fall     = w_in_shift & ~i_sclk &  r_sclk_q;

    // Ready only while the divider is idle; a pending config request wins
    // over a transmit in the same cycle.
    assign w_tx_ready = i_rst_n & (r_state == ST_IDLE) & i_div_idle & ~i_cdiv_load;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state       <= ST_RESET;
            r_tx_shift    <= 8'h00;
            r_rx_shift    <= 8'h00;
            r_edge_cnt    <= 4'd0;
            r_sclk_q      <= 1'b0;
            r_cs_n        <= 1'b1;
            r_mosi        <= 1'b0;
            r_div_start_n <= 1'b1;
            r_div_config  <= 9'd0;
            r_rx_data     <= 8'h00;
            r_rx_valid    <= 1'b0;
        end else begin
            // Single-cycle pulses fall back to their inactive values.
            r_div_start_n <= 1'b1;
            r_div_config  <= 9'd0;
            r_rx_valid    <= 1'b0;
            // Edge history is only meaningful inside SHIFT; clearing it
            // elsewhere keeps a stale high level from looking like a fall.
            r_sclk_q      <= w_in_shift ? i_sclk : 1'b0;

            case (r_state)
                ST_RESET: begin
                    r_state <= ST_IDLE;
                end

                ST_IDLE: begin
                    if (i_cdiv_load && i_div_idle) begin
                        r_div_config <= {i_cdiv, 1'b1};
                        r_state      <= ST_CFG;
                    end else if (i_tx_valid && w_tx_ready) begin
                        r_tx_shift    <= i_tx_data;
                        r_rx_shift    <= 8'h00;
                        r_edge_cnt    <= 4'd0;
                        r_cs_n        <= 1'b0;
                        r_mosi        <= w_tx_first_bit;
                        r_div_start_n <= 1'b0;
                        r_state       <= ST_START;
                    end
                end

                ST_CFG: begin
                    r_state <= ST_CFG_WAIT;
                end

                ST_CFG_WAIT: begin
                    if (i_div_idle) begin
                        r_state <= ST_IDLE;
                    end
                end

                ST_START: begin
                    r_state <= ST_SHIFT;
                end

                ST_SHIFT: begin
                    if (w_rise) begin
                        r_rx_shift <= w_rx_shifted;
                    end
                    if (w_fall) begin
                        r_edge_cnt <= r_edge_cnt + 4'd1;
                        if (r_edge_cnt == 4'd7) begin
                            // Last fall: all eight bits were sampled on the
                            // preceding rises; MOSI is left on the last bit.
                            r_rx_data  <= r_rx_shift;
                            r_rx_valid <= 1'b1;
                            r_state    <= ST_DONE;
                        end else begin
                            r_tx_shift <= w_tx_rotated;
                            r_mosi     <= w_tx_next_bit;
                        end
                    end
                end

                ST_DONE: begin
                    r_cs_n  <= 1'b1;
                    r_mosi  <= 1'b0;
                    r_state <= ST_IDLE;
                end

                default: begin
                    r_state <= ST_RESET;
                end
            endcase
        end
    end

    assign o_tx_ready    = w_tx_ready;
    assign o_rx_data     = r_rx_data;
    assign o_rx_valid    = r_rx_valid;
    assign o_div_config  = r_div_config;
    assign o_div_start_n = r_div_start_n;
    assign o_sclk        = i_sclk & ~r_cs_n;
    assign o_mosi        = r_mosi;
    assign o_cs_n        = r_cs_n;

endmodule
